// File: rtl/vga_fb_arbiter_if.sv
// Bundles the pixel-source, host and framebuffer-RAM signals around vga_fb_arbiter.
// master = arbiter side, slave = surrounding logic (sync generator, host, RAM, output stage).
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
);
    logic              PixelTick;
    logic [9:0]        PixelX;
    logic [9:0]        PixelY;
    logic [DATA_W-1:0] RGB;
    logic              HostReq;
    logic [ADDR_W-1:0] HostAddr;
    logic [DATA_W-1:0] HostWData;
    logic              HostAck;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemWe;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;
`ifdef VGA_FB_READBACK_EN
    logic              HostWe;
    logic [DATA_W-1:0] HostRData;

    modport master (
        input  PixelTick, PixelX, PixelY, HostReq, HostAddr, HostWData, HostWe, MemRData,
        output RGB, HostAck, HostRData, MemAddr, MemWe, MemWData
    );
    modport slave (
        output PixelTick, PixelX, PixelY, HostReq, HostAddr, HostWData, HostWe, MemRData,
        input  RGB, HostAck, HostRData, MemAddr, MemWe, MemWData
    );
`else
    modport master (
        input  PixelTick, PixelX, PixelY, HostReq, HostAddr, HostWData, MemRData,
        output RGB, HostAck, MemAddr, MemWe, MemWData
    );
    modport slave (
        output PixelTick, PixelX, PixelY, HostReq, HostAddr, HostWData, MemRData,
        input  RGB, HostAck, MemAddr, MemWe, MemWData
    );
`endif
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between look-ahead pixel reads and host writes (VGA_FB_READBACK_EN adds host reads).
// Latency: pixel colour registered on the PixelTick after its read; host acked combinationally when issued, <=2 cycles in active video.
// Backpressure: host holds HostReq until HostAck; a visible-pixel read always owns its slot.
module vga_fb_arbiter #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 12
) (
    input  logic             Clk,
    input  logic             Reset,
    vga_fb_arbiter_if.master bus
);
    localparam int          FB_W    = H_RES >> SCALE_SHIFT;
    localparam int          FB_H    = V_RES >> SCALE_SHIFT;
    localparam logic [31:0] FB_SIZE = 32'(FB_W * FB_H);
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS   = 10'(H_RES);
    localparam logic [9:0]  V_VIS   = 10'(V_RES);

    logic              tick_d;
    logic              fetch_pending;
    logic [DATA_W-1:0] rgb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [9:0]        nx;
    logic [9:0]        ny;
    logic              next_vis;
    logic [ADDR_W-1:0] video_addr;
    logic              vid_read;
    logic              host_go;
    logic              host_wr;
    logic              host_in_range;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              host_ack;

    // Coordinate of the pixel that follows the one currently on the counters.
    always_comb begin
        nx = '0;
        ny = bus.PixelY;
        if (bus.PixelX < H_LAST) begin
            nx = bus.PixelX + 10'd1;
        end else if (bus.PixelY == V_LAST) begin
            ny = '0;
        end else begin
            ny = bus.PixelY + 10'd1;
        end
    end

    assign next_vis   = (nx < H_VIS) && (ny < V_VIS);
    assign video_addr = ADDR_W'(20'(ny >> SCALE_SHIFT) * 20'(FB_W) + 20'(nx >> SCALE_SHIFT));

    assign vid_read      = !Reset && tick_d && next_vis;
    assign host_go       = !Reset && !vid_read && bus.HostReq;
    assign host_in_range = 32'(bus.HostAddr) < FB_SIZE;

`ifdef VGA_FB_READBACK_EN
    assign host_wr = bus.HostWe;
`else
    assign host_wr = 1'b1;
`endif

    // Address/data hold their last issued value so the RAM pins stay quiet when idle.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        host_ack  = 1'b0;
        if (Reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (vid_read) begin
            mem_addr = video_addr;
        end else if (host_go) begin
            mem_addr  = bus.HostAddr;
            mem_wdata = bus.HostWData;
            mem_we    = host_wr && host_in_range;
            host_ack  = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            tick_d        <= 1'b0;
            fetch_pending <= 1'b0;
            rgb_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            tick_d  <= bus.PixelTick;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            if (bus.PixelTick) begin
                rgb_q         <= fetch_pending ? bus.MemRData : '0;
                fetch_pending <= 1'b0;
            end else if (vid_read) begin
                fetch_pending <= 1'b1;
            end
        end
    end

`ifdef VGA_FB_READBACK_EN
    logic              rd_pending;
    logic              rd_in_range;
    logic [DATA_W-1:0] host_rdata_q;

    // Read data arrives one cycle after the ack; out-of-range reads return zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_pending   <= 1'b0;
            rd_in_range  <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            rd_pending  <= host_go && !host_wr;
            rd_in_range <= host_in_range;
            if (rd_pending) begin
                host_rdata_q <= rd_in_range ? bus.MemRData : '0;
            end
        end
    end

    assign bus.HostRData = host_rdata_q;
`endif

    assign bus.RGB      = rgb_q;
    assign bus.HostAck  = host_ack;
    assign bus.MemAddr  = mem_addr;
    assign bus.MemWe    = mem_we;
    assign bus.MemWData = mem_wdata;
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbitrates a single-port synchronous framebuffer RAM between the VGA pixel fetch path and a host writer. It sits between the sync generator's pixel-source outputs (PixelTick, PixelX, PixelY) and the output stage's RGB input. It issues look-ahead reads so each pixel's colour is registered exactly when that pixel appears. Host accesses are served in every cycle the video path does not need the RAM.

## Interface
Parameters:
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines
- H_TOTAL, 800, pixel clocks per line including blanking
- V_TOTAL, 525, lines per frame including blanking
- SCALE_SHIFT, 2, log2 of the pixel replication factor; framebuffer is (H_RES>>SCALE_SHIFT) x (V_RES>>SCALE_SHIFT)
- ADDR_W, 15, RAM address width
- DATA_W, 12, RAM word / RGB width

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- PixelTick  in  1  one-cycle pulse every 2nd Clk; PixelX/PixelY update the cycle after it
- PixelX  in  10  current pixel column, 0..H_TOTAL-1
- PixelY  in  10  current line, 0..V_TOTAL-1
- RGB  out  DATA_W  registered colour for the current pixel
- HostReq  in  1  access request; held high with HostAddr/HostWData stable until HostAck
- HostAddr  in  ADDR_W  framebuffer word address
- HostWData  in  DATA_W  write data
- HostAck  out  1  one-cycle pulse in the cycle the access is issued
- MemAddr  out  ADDR_W  RAM address
- MemWe  out  1  RAM write enable
- MemWData  out  DATA_W  RAM write data
- MemRData  in  DATA_W  RAM read data, valid 1 cycle after address

## Operation
- TickD is a register holding PixelTick from the previous cycle.
- Video slot: the cycle with TickD=1. All other cycles are host slots.
- Look-ahead coordinate (NX, NY) is computed from the current PixelX/PixelY:
  - If PixelX < H_TOTAL-1: NX=PixelX+1, NY=PixelY.
  - Otherwise NX=0, and NY=PixelY+1, wrapping to 0 when PixelY=V_TOTAL-1.
- NextVis = (NX < H_RES) && (NY < V_RES).
- Video address = (NY>>SCALE_SHIFT)*(H_RES>>SCALE_SHIFT) + (NX>>SCALE_SHIFT). Computed at 20 bits, truncated to ADDR_W.
- Video slot with NextVis=1: MemAddr=video address, MemWe=0, and a FetchPending flag is set. The host is not served.
- Video slot with NextVis=0: the slot is released to the host, and RGB loads 0 at the next PixelTick.
- Host slot: if HostReq=1 is seen, drive MemAddr=HostAddr, MemWData=HostWData, MemWe=1, and HostAck=1 in the same cycle.
  - If HostAddr >= FB_SIZE, where FB_SIZE = (H_RES>>SCALE_SHIFT)*(V_RES>>SCALE_SHIFT), HostAck is still pulsed but MemWe stays 0.
- HostAck never asserts in two consecutive cycles for the same request. The host drops or changes HostReq in the cycle after the ack.
- In a cycle with PixelTick=1: RGB <= FetchPending ? MemRData : 0. FetchPending is cleared.
- Idle outputs when no access is issued: MemWe=0, MemAddr holds its last value, MemWData holds its last value.

## Timing
- Reset values: RGB=0, HostAck=0, MemWe=0, MemAddr=0, MemWData=0, TickD=0, FetchPending=0.
- Video pipeline:
  - Cycle T: video slot, read issued.
  - Cycle T+1: PixelTick=1, MemRData valid, RGB captured at the end of the cycle.
  - Cycles T+2..T+3: counters show pixel (NX, NY) and RGB holds its colour.
- Host latency: at most 2 cycles from HostReq rising to HostAck during active video. During blanking it is 0 cycles, i.e. acked in the same cycle.
- PixelTick and a video slot cannot coincide.
- Reset in mid-request: the request is dropped and not acked. The host keeps HostReq high and is served after Reset falls.
- Reset in mid-fetch: RGB stays 0 until the next valid fetch completes.

## Configuration
- Macro VGA_FB_READBACK_EN.
- Defined:
  - Adds port HostWe (in, 1) and port HostRData (out, DATA_W, reset 0).
  - HostWe=1 performs a write as above.
  - HostWe=0 issues a read with MemWe=0. HostRData loads MemRData the cycle after HostAck and holds it until the next host read.
  - An out-of-range read returns 0.
- Undefined: HostWe and HostRData are absent, and every host access is a write.

## Test plan
- After Reset, PixelX=3, PixelY=5, PixelTick pulse → video slot MemAddr=161, MemWe=0. With MemRData=0x5A5 at the next tick, RGB=0x5A5 while PixelX=4.
- PixelX=799, PixelY=9 → fetch address 320. PixelX=799, PixelY=524 → address 0 (frame wrap). PixelX=639, PixelY=0 → no read, RGB=0 for pixel 640.
- HostReq with HostAddr=161, HostWData=0xABC during active video → HostAck within 2 cycles with MemWe=1, never in a video slot. The next fetch of (4,5) returns 0xABC on RGB.
- HostReq with HostAddr=19200 → HostAck pulses once, MemWe stays 0.
- During vertical blanking (PixelY=500), 8 back-to-back requests → 8 acks, each one cycle after the previous request is re-presented; no video reads.
- Reset asserted in the cycle HostReq rises → no HostAck, all outputs 0. After release, HostAck arrives within 2 cycles. With VGA_FB_READBACK_EN, a read of address 161 returns 0xABC on HostRData.
